// File: rtl/audio_mixer.sv
// audio_mixer: time-multiplexed CHANNELS-input volume/pan mixer with one
// first-order sigma-delta modulator per stereo side.
// Each clock one channel is scaled by its volume and added to the left
// and/or right frame accumulators. At the end of each frame the sums are
// latched into mixL/mixR, which feed the 1-bit modulators.
module audio_mixer #(
    parameter int CHANNELS = 4,
    parameter int DW       = 6,
    parameter int VW       = 4,
    parameter int AW       = DW + VW + $clog2(CHANNELS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CHANNELS*DW-1:0] d,
    input  logic [CHANNELS*VW-1:0] vol,
    input  logic [2*CHANNELS-1:0]  pan,
    input  logic                   mute,
    output logic                   frame,
    output logic [AW-1:0]          mixL,
    output logic [AW-1:0]          mixR,
    output logic [1:0]             audio
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = DW + VW;
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

    logic [CW-1:0] ch_r;
    logic [AW-1:0] acc_l_r;
    logic [AW-1:0] acc_r_r;
    logic [AW-1:0] mix_l_r;
    logic [AW-1:0] mix_r_r;
    logic          frame_r;
    logic [AW:0]   sd_l_r;
    logic [AW:0]   sd_r_r;
    logic [1:0]    audio_r;

    logic [DW-1:0] d_sel_s;
    logic [VW-1:0] vol_sel_s;
    logic          pan_l_s;
    logic          pan_r_s;
    logic [PW-1:0] prod_s;
    logic [AW-1:0] add_l_s;
    logic [AW-1:0] add_r_s;
    logic [AW-1:0] sum_l_s;
    logic [AW-1:0] sum_r_s;
    logic          last_s;

    // Select the channel being scanned this cycle and form its scaled contribution.
    always_comb begin
        d_sel_s   = d[int'(ch_r)*DW +: DW];
        vol_sel_s = vol[int'(ch_r)*VW +: VW];
        pan_l_s   = pan[2*int'(ch_r)];
        pan_r_s   = pan[2*int'(ch_r) + 1];
        prod_s    = PW'(d_sel_s) * PW'(vol_sel_s);
        add_l_s   = pan_l_s ? AW'(prod_s) : {AW{1'b0}};
        add_r_s   = pan_r_s ? AW'(prod_s) : {AW{1'b0}};
        sum_l_s   = acc_l_r + add_l_s;
        sum_r_s   = acc_r_r + add_r_s;
        last_s    = (ch_r == LAST_CH);
    end

    // Channel scan, frame accumulation, end-of-frame latching and frame pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ch_r    <= {CW{1'b0}};
            acc_l_r <= {AW{1'b0}};
            acc_r_r <= {AW{1'b0}};
            mix_l_r <= {AW{1'b0}};
            mix_r_r <= {AW{1'b0}};
            frame_r <= 1'b0;
        end else begin
            frame_r <= last_s;
            if (last_s) begin
                // The last channel's contribution is folded in before latching.
                ch_r    <= {CW{1'b0}};
                acc_l_r <= {AW{1'b0}};
                acc_r_r <= {AW{1'b0}};
                mix_l_r <= mute ? {AW{1'b0}} : sum_l_s;
                mix_r_r <= mute ? {AW{1'b0}} : sum_r_s;
            end else begin
                ch_r    <= ch_r + {{(CW-1){1'b0}}, 1'b1};
                acc_l_r <= sum_l_s;
                acc_r_r <= sum_r_s;
            end
        end
    end

    // First-order sigma-delta per side; the carry out of each update becomes the output bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sd_l_r  <= {(AW+1){1'b0}};
            sd_r_r  <= {(AW+1){1'b0}};
            audio_r <= 2'b00;
        end else begin
            sd_l_r  <= {1'b0, sd_l_r[AW-1:0]} + {1'b0, mix_l_r};
            sd_r_r  <= {1'b0, sd_r_r[AW-1:0]} + {1'b0, mix_r_r};
            audio_r <= {sd_r_r[AW], sd_l_r[AW]};
        end
    end

    assign frame = frame_r;
    assign mixL  = mix_l_r;
    assign mixR  = mix_r_r;
    assign audio = audio_r;

endmodule

// File: tb/tb_audio_mixer.sv
// Directed self-checking bench for audio_mixer with default parameters
// (4 channels, 6-bit samples, 4-bit volumes, 12-bit mix).
module tb_audio_mixer;

    localparam int CHANNELS = 4;
    localparam int DW       = 6;
    localparam int VW       = 4;
    localparam int AW       = 12;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [CHANNELS*DW-1:0] d     = '0;
    logic [CHANNELS*VW-1:0] vol   = '0;
    logic [2*CHANNELS-1:0]  pan   = '0;
    logic                   mute  = 1'b0;
    logic                   frame;
    logic [AW-1:0]          mixL;
    logic [AW-1:0]          mixR;
    logic [1:0]             audio;

    int cmp_cnt = 0;
    int err_cnt = 0;

    audio_mixer #(.CHANNELS(CHANNELS), .DW(DW), .VW(VW)) dut (
        .clock (clock),
        .reset (reset),
        .d     (d),
        .vol   (vol),
        .pan   (pan),
        .mute  (mute),
        .frame (frame),
        .mixL  (mixL),
        .mixR  (mixR),
        .audio (audio)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge at which frame is high, bounded.
    task automatic wait_frame(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 3*CHANNELS && !seen; k++) begin
            @(negedge clock);
            if (frame === 1'b1) seen = 1'b1;
        end
        if (!seen) check({tag, "_frame_timeout"}, 32'd0, 32'd1);
    endtask

    // Count ones on each audio bit over 4096 clocks once the mix has settled.
    task automatic count_ones(output int ones_l, output int ones_r);
        ones_l = 0;
        ones_r = 0;
        repeat (4) @(negedge clock);
        for (int k = 0; k < 4096; k++) begin
            @(negedge clock);
            ones_l += int'(audio[0]);
            ones_r += int'(audio[1]);
        end
    endtask

    initial begin
        int ol;
        int orr;
        int zeros_ok;

        // Reset held with random inputs.
        d    = CHANNELS*DW'($urandom);
        vol  = CHANNELS*VW'($urandom);
        pan  = 8'($urandom);
        mute = 1'($urandom);
        repeat (3) @(negedge clock);
        check("rst_audio", 32'(audio), 32'd0);
        check("rst_mixL",  32'(mixL),  32'd0);
        check("rst_mixR",  32'(mixR),  32'd0);
        check("rst_frame", 32'(frame), 32'd0);

        // Single channel, released at a negedge; first frame after 4 clocks.
        d    = {6'd0, 6'd0, 6'd0, 6'd63};
        vol  = {4'd0, 4'd0, 4'd0, 4'd15};
        pan  = 8'b00000011;
        mute = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("first_frame_early", 32'(frame), 32'd0);
        @(negedge clock);
        check("first_frame", 32'(frame), 32'd1);
        check("single_mixL", 32'(mixL), 32'd945);
        check("single_mixR", 32'(mixR), 32'd945);
        count_ones(ol, orr);
        check("single_ones_l", 32'(ol),  32'd945);
        check("single_ones_r", 32'(orr), 32'd945);

        // Panning: channel 1 to the right only.
        wait_frame("pan_a");
        d   = {6'd0, 6'd0, 6'd10, 6'd0};
        vol = {4'd0, 4'd0, 4'd15, 4'd0};
        pan = 8'b00001000;
        wait_frame("pan_b");
        check("pan_mixL", 32'(mixL), 32'd0);
        check("pan_mixR", 32'(mixR), 32'd150);
        repeat (3) @(negedge clock);
        zeros_ok = 1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            if (audio[0] !== 1'b0) zeros_ok = 0;
        end
        check("pan_left_silent", 32'(zeros_ok), 32'd1);

        // Full scale on every channel, both sides.
        wait_frame("full_a");
        d   = {4{6'd63}};
        vol = {4{4'd15}};
        pan = 8'hFF;
        wait_frame("full_b");
        check("full_mixL", 32'(mixL), 32'd3780);
        check("full_mixR", 32'(mixR), 32'd3780);
        count_ones(ol, orr);
        check("full_ones_l", 32'(ol),  32'd3780);
        check("full_ones_r", 32'(orr), 32'd3780);

        // Volume zero then half-ish volume.
        wait_frame("vol_a");
        d   = {6'd0, 6'd0, 6'd0, 6'd63};
        vol = {4'd0, 4'd0, 4'd0, 4'd0};
        pan = 8'b00000011;
        wait_frame("vol_b");
        check("vol0_mixL", 32'(mixL), 32'd0);
        vol = {4'd0, 4'd0, 4'd0, 4'd8};
        wait_frame("vol_c");
        check("vol8_mixL", 32'(mixL), 32'd504);
        check("vol8_mixR", 32'(mixR), 32'd504);

        // Mute raised mid-frame takes effect only at the frame end.
        repeat (2) @(negedge clock);
        mute = 1'b1;
        @(negedge clock);
        check("mute_pending_mixL",  32'(mixL),  32'd504);
        check("mute_pending_frame", 32'(frame), 32'd0);
        @(negedge clock);
        check("mute_edge_frame", 32'(frame), 32'd1);
        check("mute_mixL", 32'(mixL), 32'd0);
        check("mute_mixR", 32'(mixR), 32'd0);
        mute = 1'b0;
        wait_frame("unmute");
        check("unmute_mixL", 32'(mixL), 32'd504);

        // Reset in the middle of a frame (ch = 2).
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_mixL",  32'(mixL),  32'd0);
        check("midrst_mixR",  32'(mixR),  32'd0);
        check("midrst_audio", 32'(audio), 32'd0);
        check("midrst_frame", 32'(frame), 32'd0);
        repeat (2) @(negedge clock);
        check("midrst_hold_frame", 32'(frame), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("post_rst_no_frame", 32'(frame), 32'd0);
        end
        @(negedge clock);
        check("post_rst_frame", 32'(frame), 32'd1);
        check("post_rst_mixL", 32'(mixL), 32'd504);
        check("post_rst_mixR", 32'(mixR), 32'd504);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/audio_mixer.md
Name: audio_mixer

Overview:
- Parametrised successor to the single-source ear/DAC audio path.
- Time-multiplexes CHANNELS unsigned sample sources, one channel per clock, applying a per-channel volume and a per-channel left/right pan enable.
- Drives one first-order sigma-delta modulator per stereo side, producing 1-bit left/right audio.
- Sits between the machine's sound sources (beeper/ear, DAC, expansion sound chips) and the board audio pins.

Parameters:
- CHANNELS, 4, number of input channels; legal range 2..16.
- DW, 6, sample width per channel (unsigned).
- VW, 4, volume width per channel (unsigned; 0 = silent, all-ones = full).

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- d  in  CHANNELS*DW  packed samples; channel i occupies bits [i*DW +: DW].
- vol  in  CHANNELS*VW  packed volumes; channel i occupies bits [i*VW +: VW].
- pan  in  2*CHANNELS  bit 2i = channel i to left, bit 2i+1 = channel i to right.
- mute  in  1  silences both sides from the next frame boundary.
- frame  out  1  one-clock pulse when mixL/mixR update.
- mixL  out  AW  latched left mix; AW = DW+VW+clog2(CHANNELS).
- mixR  out  AW  latched right mix.
- audio  out  2  {right, left} sigma-delta bitstreams.

Behaviour:
- Reset (reset low, asynchronous): the following are all 0.
  - Channel counter, accumulators accL/accR, mixL, mixR, both sigma-delta accumulators, audio, frame.
- Channel counter `ch`:
  - Width max(1, clog2(CHANNELS)).
  - Increments every clock; wraps from CHANNELS-1 to 0.
  - One frame = CHANNELS clocks.
- Per clock with ch = i:
  - Sample d[i] and vol[i] in that cycle.
  - Product p = d[i]*vol[i], width DW+VW, unsigned, no rounding.
  - accL gets p added if pan[2i]; accR gets p added if pan[2i+1]; otherwise the accumulator holds.
- Frame end (clock edge where ch = CHANNELS-1):
  - mixL/mixR are loaded with accL/accR including channel CHANNELS-1's contribution; load 0 if mute is high on that edge.
  - accL/accR are cleared to 0 on the same edge.
  - frame = 1 for exactly the following cycle.
- Mix latency: an input change on channel i is reflected in mixL/mixR at most 2*CHANNELS clocks later.
- No overflow: maximum sum CHANNELS*(2^DW-1)*(2^VW-1) < 2^AW. No saturation logic is required.
- Sigma-delta modulator, each side:
  - Accumulator sd of width AW+1.
  - Every clock: sd <= {1'b0, sd[AW-1:0]} + mix.
  - Output bit = sd[AW], registered (audio bit = carry of the previous update).
  - Ones density over 2^AW consecutive clocks with constant mix = mix exactly.
- Mute and input timing:
  - mute is sampled only at the frame end. Asserting it mid-frame has no effect until the frame end; deasserting it restores the next frame's mix.
  - vol/pan/d changes mid-frame affect only channels not yet scanned in that frame. No glitch filtering.
- Reset mid-frame: the partial frame is discarded; after release ch restarts at 0; the first frame pulse occurs CHANNELS clocks after release.

Test Plan:
- Reset: hold reset low with random inputs -> audio=0, mixL=mixR=0, frame=0. Release -> first frame pulse exactly 4 clocks later.
- Single channel (defaults): d0=63, vol0=15, pan=8'b00000011, others 0 -> mixL=mixR=945. Over 4096 clocks, count of audio[0]=1 is 945, same for audio[1].
- Panning: d1=10, vol1=15, pan=8'b00001000 -> mixL=0, mixR=150; audio[0] stays 0.
- Full scale: all d=63, vol=15, pan=8'hFF -> mixL=3780 (no wrap); ones count 3780 per 4096 clocks.
- Volume and mute: vol0=0 -> mix 0. Then vol0=8 with d0=63 -> 504. Assert mute mid-frame -> mix stays 504 until the next frame edge, then 0. Release mute -> 504 at the following frame.
- Reset mid-frame at ch=2 -> all outputs 0 immediately; no frame pulse from the partial frame; normal mixing resumes after release.
